// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI slave constants: FSM encoding, mode and timing limits
package spi_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_PREFETCH = 2'd0;
  localparam state_t ST_STREAM   = 2'd1;
  localparam state_t ST_CAPTURE  = 2'd2;
  localparam state_t ST_DONE     = 2'd3;

  localparam int CPHA                = 0;
  localparam int MIN_SCLK_PERIOD_CLK = 8;
  localparam int MIN_SS_SETUP_CLK    = 6;

endpackage

// File: rtl/spi_stream_slave_if.sv
// rtl/spi_stream_slave_if.sv - SPI pins plus byte-memory read port of the stream slave
interface spi_stream_slave_if #(
  parameter int ADDR_W = 15
);
  logic              spi_sclk;
  logic              spi_mosi;
  logic              spi_ss_out;
  logic              spi_miso;
  logic              spi_miso_oe;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [7:0]        mem_rd_data;

  modport slave (
    input  spi_sclk, spi_mosi, spi_ss_out, mem_rd_data,
    output spi_miso, spi_miso_oe, mem_rd_en, mem_rd_addr
  );

  modport master (
    output spi_sclk, spi_mosi, spi_ss_out, mem_rd_data,
    input  spi_miso, spi_miso_oe, mem_rd_en, mem_rd_addr
  );
endinterface

// File: rtl/spi_pin_sync.sv
// rtl/spi_pin_sync.sv - oversampling synchroniser and CPOL-aware edge detector for SPI pins
module spi_pin_sync #(
  parameter int SYNC_STAGES = 2,
  parameter bit CPOL        = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic sclk_i,
  input  logic mosi_i,
  input  logic ss_n_i,
  output logic sclk_lead_o,
  output logic sclk_trail_o,
  output logic ss_active_o,
  output logic mosi_o
);

  logic [SYNC_STAGES-1:0] sclk_q;
  logic [SYNC_STAGES-1:0] mosi_q;
  logic [SYNC_STAGES-1:0] ss_q;
  logic                   sclk_prev_q;
  logic                   sclk_s;
  logic                   rise;
  logic                   fall;

  // Reset to the idle pin levels so leaving reset never fakes an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_q      <= {SYNC_STAGES{CPOL}};
      mosi_q      <= '0;
      ss_q        <= '1;
      sclk_prev_q <= CPOL;
    end else begin
      sclk_q      <= {sclk_q[SYNC_STAGES-2:0], sclk_i};
      mosi_q      <= {mosi_q[SYNC_STAGES-2:0], mosi_i};
      ss_q        <= {ss_q[SYNC_STAGES-2:0], ss_n_i};
      sclk_prev_q <= sclk_q[SYNC_STAGES-1];
    end
  end

  assign sclk_s       = sclk_q[SYNC_STAGES-1];
  assign rise         = sclk_s & ~sclk_prev_q;
  assign fall         = ~sclk_s & sclk_prev_q;
  assign ss_active_o  = ~ss_q[SYNC_STAGES-1];
  assign mosi_o       = mosi_q[SYNC_STAGES-1];
  assign sclk_lead_o  = ss_active_o & (CPOL ? fall : rise);
  assign sclk_trail_o = ss_active_o & (CPOL ? rise : fall);

endmodule

// File: rtl/spi_stream_slave.sv
// rtl/spi_stream_slave.sv - CPHA=0 SPI slave streaming a memory image out, then capturing a result
module spi_stream_slave
  import spi_pkg::*;
#(
  parameter int DATA_BITS    = 160176,
  parameter int RESULT_BYTES = 2,
  parameter int ADDR_W       = 15,
  parameter bit CPOL         = 1'b0,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  spi_stream_slave_if.slave         bus,
  output logic [8*RESULT_BYTES-1:0] result_data,
  output logic                      result_valid,
  output logic                      busy,
  output logic                      done
);

  localparam int RES_W     = 8 * RESULT_BYTES;
  localparam int NUM_BYTES = (DATA_BITS + 7) / 8;
  localparam int CNT_W     = $clog2(DATA_BITS + 1);
  localparam int CAP_W     = $clog2(RES_W + 1);
  localparam logic [ADDR_W:0] END_ADDR = (ADDR_W+1)'(NUM_BYTES);

  logic sclk_lead, sclk_trail, ss_active, mosi_s;

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .CPOL(CPOL)) u_sync (
    .clk          (clk),
    .rst          (rst),
    .sclk_i       (bus.spi_sclk),
    .mosi_i       (bus.spi_mosi),
    .ss_n_i       (bus.spi_ss_out),
    .sclk_lead_o  (sclk_lead),
    .sclk_trail_o (sclk_trail),
    .ss_active_o  (ss_active),
    .mosi_o       (mosi_s)
  );

  state_t             state_q, state_d;
  logic               pf_q, pf_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [2:0]         sub_q, sub_d;
  logic [ADDR_W:0]    next_addr_q, next_addr_d;
  logic [7:0]         shift_q, shift_d;
  logic [7:0]         hold_q, hold_d;
  logic               hold_pend_q, hold_pend_d;
  logic [CAP_W-1:0]   cap_cnt_q, cap_cnt_d;
  logic [RES_W-1:0]   res_sh_q, res_sh_d;
  logic [RES_W-1:0]   result_q, result_d;
  logic               rv_q, rv_d;
  logic               seen_ss_q, seen_ss_d;
  logic               rd_en;
  logic [ADDR_W-1:0]  rd_addr;

  always_comb begin
    state_d     = state_q;
    pf_d        = pf_q;
    bit_cnt_d   = bit_cnt_q;
    sub_d       = sub_q;
    next_addr_d = next_addr_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_pend_d = 1'b0;
    cap_cnt_d   = cap_cnt_q;
    res_sh_d    = res_sh_q;
    result_d    = result_q;
    rv_d        = 1'b0;
    seen_ss_d   = seen_ss_q | ss_active;
    rd_en       = 1'b0;
    rd_addr     = '0;

    // Memory answers one clk after the strobe; land it in the holding register.
    if (hold_pend_q) hold_d = bus.mem_rd_data;

    case (state_q)
      ST_PREFETCH: begin
        if (!pf_q) begin
          rd_en = 1'b1;
          pf_d  = 1'b1;
        end else begin
          shift_d     = bus.mem_rd_data;
          next_addr_d = (ADDR_W+1)'(2);
          state_d     = ST_STREAM;
          if (NUM_BYTES > 1) begin
            rd_en       = 1'b1;
            rd_addr     = ADDR_W'(1);
            hold_pend_d = 1'b1;
          end
        end
      end
      ST_STREAM: begin
        if (sclk_trail) begin
          if (bit_cnt_q == '0) begin
            state_d = ST_CAPTURE;
          end else begin
            bit_cnt_d = bit_cnt_q - CNT_W'(1);
            if (sub_q == 3'd0) begin
              shift_d = hold_q;
              sub_d   = 3'd7;
              if (next_addr_q < END_ADDR) begin
                rd_en       = 1'b1;
                rd_addr     = next_addr_q[ADDR_W-1:0];
                next_addr_d = next_addr_q + (ADDR_W+1)'(1);
                hold_pend_d = 1'b1;
              end
            end else begin
              shift_d = {shift_q[6:0], 1'b0};
              sub_d   = sub_q - 3'd1;
            end
          end
        end
      end
      ST_CAPTURE: begin
        if (sclk_lead) begin
          res_sh_d  = {res_sh_q[RES_W-2:0], mosi_s};
          cap_cnt_d = cap_cnt_q + CAP_W'(1);
          if (cap_cnt_q == CAP_W'(RES_W - 1)) begin
            result_d = {res_sh_q[RES_W-2:0], mosi_s};
            rv_d     = 1'b1;
            state_d  = ST_DONE;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_PREFETCH;
      pf_q        <= 1'b0;
      bit_cnt_q   <= CNT_W'(DATA_BITS - 1);
      sub_q       <= 3'd7;
      next_addr_q <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_pend_q <= 1'b0;
      cap_cnt_q   <= '0;
      res_sh_q    <= '0;
      result_q    <= '0;
      rv_q        <= 1'b0;
      seen_ss_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pf_q        <= pf_d;
      bit_cnt_q   <= bit_cnt_d;
      sub_q       <= sub_d;
      next_addr_q <= next_addr_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_pend_q <= hold_pend_d;
      cap_cnt_q   <= cap_cnt_d;
      res_sh_q    <= res_sh_d;
      result_q    <= result_d;
      rv_q        <= rv_d;
      seen_ss_q   <= seen_ss_d;
    end
  end

  // The first prefetch strobe is combinational, so mask it while rst is held.
  assign bus.mem_rd_en   = rd_en & ~rst;
  assign bus.mem_rd_addr = rd_addr;
  assign bus.spi_miso    = (state_q == ST_STREAM) & shift_q[7];
  assign bus.spi_miso_oe = ss_active;
  assign result_data     = result_q;
  assign result_valid    = rv_q;
  assign busy            = seen_ss_q & (state_q != ST_DONE);
  assign done            = (state_q == ST_DONE);

endmodule

// File: tb/tb_spi_stream_slave.sv
// tb/tb_spi_stream_slave.sv - directed bench for spi_stream_slave (CPOL 0/1, partial byte, pause, reset)
module tb_spi_stream_slave;
  import spi_pkg::*;

  localparam int HALF = MIN_SCLK_PERIOD_CLK / 2 + 1;
  localparam int SETUP = MIN_SS_SETUP_CLK + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_stream_slave_if #(.ADDR_W(4)) bus_a ();
  spi_stream_slave_if #(.ADDR_W(4)) bus_b ();
  spi_stream_slave_if #(.ADDR_W(4)) bus_c ();

  logic [15:0] res_v [3];
  logic        rv_v [3];
  logic        busy_v [3];
  logic        done_v [3];
  logic        miso_v [3];
  logic        oe_v [3];
  logic        sclk_p [3];
  logic        mosi_p [3];
  logic        ss_p [3];
  int          rv_cnt [3];
  int          hi_b;
  int          tests;
  int          fails;

  spi_stream_slave #(.DATA_BITS(16), .RESULT_BYTES(2), .ADDR_W(4), .CPOL(1'b0), .SYNC_STAGES(2)) u_a (
    .clk(clk), .rst(rst), .bus(bus_a.slave),
    .result_data(res_v[0]), .result_valid(rv_v[0]), .busy(busy_v[0]), .done(done_v[0]));
  spi_stream_slave #(.DATA_BITS(12), .RESULT_BYTES(2), .ADDR_W(4), .CPOL(1'b0), .SYNC_STAGES(2)) u_b (
    .clk(clk), .rst(rst), .bus(bus_b.slave),
    .result_data(res_v[1]), .result_valid(rv_v[1]), .busy(busy_v[1]), .done(done_v[1]));
  spi_stream_slave #(.DATA_BITS(16), .RESULT_BYTES(2), .ADDR_W(4), .CPOL(1'b1), .SYNC_STAGES(2)) u_c (
    .clk(clk), .rst(rst), .bus(bus_c.slave),
    .result_data(res_v[2]), .result_valid(rv_v[2]), .busy(busy_v[2]), .done(done_v[2]));

  assign bus_a.spi_sclk = sclk_p[0];
  assign bus_a.spi_mosi = mosi_p[0];
  assign bus_a.spi_ss_out = ss_p[0];
  assign bus_b.spi_sclk = sclk_p[1];
  assign bus_b.spi_mosi = mosi_p[1];
  assign bus_b.spi_ss_out = ss_p[1];
  assign bus_c.spi_sclk = sclk_p[2];
  assign bus_c.spi_mosi = mosi_p[2];
  assign bus_c.spi_ss_out = ss_p[2];
  assign miso_v[0] = bus_a.spi_miso;
  assign miso_v[1] = bus_b.spi_miso;
  assign miso_v[2] = bus_c.spi_miso;
  assign oe_v[0] = bus_a.spi_miso_oe;
  assign oe_v[1] = bus_b.spi_miso_oe;
  assign oe_v[2] = bus_c.spi_miso_oe;

  function automatic logic [7:0] img_a(input logic [3:0] a);
    case (a)
      4'd0: return 8'hA5;
      4'd1: return 8'h3C;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] img_b(input logic [3:0] a);
    case (a)
      4'd0: return 8'hF0;
      4'd1: return 8'hE7;
      default: return 8'h00;
    endcase
  endfunction

  always @(posedge clk) begin
    if (bus_a.mem_rd_en) bus_a.mem_rd_data <= img_a(bus_a.mem_rd_addr);
    if (bus_b.mem_rd_en) bus_b.mem_rd_data <= img_b(bus_b.mem_rd_addr);
    if (bus_c.mem_rd_en) bus_c.mem_rd_data <= img_a(bus_c.mem_rd_addr);
  end

  initial begin
    rv_cnt[0] = 0;
    rv_cnt[1] = 0;
    rv_cnt[2] = 0;
    hi_b = 0;
  end

  always @(negedge clk) begin
    for (int j = 0; j < 3; j++) if (rv_v[j]) rv_cnt[j] = rv_cnt[j] + 1;
    if (bus_b.mem_rd_en && bus_b.mem_rd_addr >= 4'd2) hi_b = hi_b + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // CPHA=0 master: MISO sampled just before each leading edge, MOSI changed after each trailing edge.
  task automatic xfer(input int k, input int n, input logic [31:0] tx, input int pause_at,
                      output logic [31:0] rx);
    logic pol;
    pol = (k == 2);
    rx = '0;
    ss_p[k] = 1'b0;
    repeat (SETUP) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      mosi_p[k] = tx[n-1-i];
      repeat (HALF) @(negedge clk);
      rx[n-1-i] = miso_v[k];
      sclk_p[k] = ~pol;
      repeat (HALF) @(negedge clk);
      sclk_p[k] = pol;
      if (i == pause_at) begin
        repeat (4) @(negedge clk);
        ss_p[k] = 1'b1;
        repeat (10) @(negedge clk);
        check("pause_oe", 32'(oe_v[k]), 32'd0);
        check("pause_busy", 32'(busy_v[k]), 32'd1);
        check("pause_done", 32'(done_v[k]), 32'd0);
        repeat (40) @(negedge clk);
        ss_p[k] = 1'b0;
        repeat (SETUP) @(negedge clk);
      end
    end
    repeat (HALF) @(negedge clk);
  endtask

  logic [31:0] rx;
  int          base;

  initial begin
    tests = 0;
    fails = 0;
    $display("[TB] spi_stream_slave bench, CPHA=%0d", CPHA);
    sclk_p[0] = 1'b0; sclk_p[1] = 1'b0; sclk_p[2] = 1'b1;
    mosi_p[0] = 1'b0; mosi_p[1] = 1'b0; mosi_p[2] = 1'b0;
    ss_p[0] = 1'b1;   ss_p[1] = 1'b1;   ss_p[2] = 1'b1;
    rst = 1'b1;
    repeat (4) @(negedge clk);

    check("rst_miso", 32'(miso_v[0]), 32'd0);
    check("rst_oe", 32'(oe_v[0]), 32'd0);
    check("rst_rd_en", 32'(bus_a.mem_rd_en), 32'd0);
    check("rst_result", 32'(res_v[0]), 32'd0);
    check("rst_valid", 32'(rv_v[0]), 32'd0);
    check("rst_busy", 32'(busy_v[0]), 32'd0);
    check("rst_done", 32'(done_v[0]), 32'd0);

    rst = 1'b0;
    #1;
    check("pf_rd0_en", 32'(bus_a.mem_rd_en), 32'd1);
    check("pf_rd0_addr", 32'(bus_a.mem_rd_addr), 32'd0);
    @(negedge clk);
    check("pf_rd1_en", 32'(bus_a.mem_rd_en), 32'd1);
    check("pf_rd1_addr", 32'(bus_a.mem_rd_addr), 32'd1);
    @(negedge clk);
    check("pf_idle", 32'(bus_a.mem_rd_en), 32'd0);

    xfer(0, 32, 32'h0000_1234, -1, rx);
    ss_p[0] = 1'b1;
    check("basic_miso", rx, 32'hA53C_0000);
    check("basic_result", 32'(res_v[0]), 32'h1234);
    check("basic_valid_cnt", 32'(rv_cnt[0]), 32'd1);
    check("basic_done", 32'(done_v[0]), 32'd1);
    check("basic_busy", 32'(busy_v[0]), 32'd0);

    xfer(0, 32, 32'hFFFF_FFFF, -1, rx);
    ss_p[0] = 1'b1;
    check("hold_miso", rx, 32'd0);
    check("hold_result", 32'(res_v[0]), 32'h1234);
    check("hold_valid_cnt", 32'(rv_cnt[0]), 32'd1);
    check("hold_done", 32'(done_v[0]), 32'd1);

    xfer(1, 28, 32'h0000_5A5A, -1, rx);
    ss_p[1] = 1'b1;
    check("part_miso", rx, 32'h0F0E_0000);
    check("part_result", 32'(res_v[1]), 32'h5A5A);
    check("part_no_addr2", 32'(hi_b), 32'd0);
    check("part_valid_cnt", 32'(rv_cnt[1]), 32'd1);

    xfer(2, 32, 32'h0000_1234, -1, rx);
    ss_p[2] = 1'b1;
    check("cpol1_miso", rx, 32'hA53C_0000);
    check("cpol1_result", 32'(res_v[2]), 32'h1234);
    check("cpol1_valid_cnt", 32'(rv_cnt[2]), 32'd1);

    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    base = rv_cnt[0];
    xfer(0, 25, 32'h0000_01FF, -1, rx);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_result", 32'(res_v[0]), 32'd0);
    check("midrst_valid", 32'(rv_v[0]), 32'd0);
    check("midrst_oe", 32'(oe_v[0]), 32'd0);
    check("midrst_miso", 32'(miso_v[0]), 32'd0);
    check("midrst_busy", 32'(busy_v[0]), 32'd0);
    check("midrst_done", 32'(done_v[0]), 32'd0);
    ss_p[0] = 1'b1;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_valid_cnt", 32'(rv_cnt[0]), 32'(base));

    xfer(0, 32, 32'h0000_BEEF, 5, rx);
    ss_p[0] = 1'b1;
    check("fresh_miso", rx, 32'hA53C_0000);
    check("fresh_result", 32'(res_v[0]), 32'hBEEF);
    check("fresh_valid_cnt", 32'(rv_cnt[0]), 32'(base + 1));
    check("fresh_done", 32'(done_v[0]), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_stream_slave.md
Name: spi_stream_slave

Overview:
- Synthesizable, parametrised SPI slave for mainframe puzzle I/O: streams a puzzle input image from a byte-wide memory out on MISO, then captures a RESULT_BYTES-wide answer from MOSI.
- Runs entirely on the system clock. SCLK, MOSI and SS are oversampled, so no SPI-clock domain exists.
- Sits between the top-level SPI pins and the input-image ROM/BRAM; its result port feeds the display/UART reporting path.

Parameters:
- DATA_BITS, 160176: number of input-image bits streamed, MSB of byte 0 first.
- RESULT_BYTES, 2: bytes captured from MOSI after the stream ends.
- ADDR_W, 15: memory byte-address width; must satisfy 2**ADDR_W >= ceil(DATA_BITS/8).
- CPOL, 0: SCLK idle level. 0 means leading edge is rising.
- SYNC_STAGES, 2: synchroniser depth on spi_sclk, spi_mosi and spi_ss_out (minimum 2).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- spi_sclk  in  1  SPI clock from master.
- spi_mosi  in  1  master-out data.
- spi_ss_out  in  1  slave select, active low.
- spi_miso  out  1  slave-out data.
- spi_miso_oe  out  1  MISO output enable; the top level tristates when 0.
- mem_rd_en  out  1  byte read strobe.
- mem_rd_addr  out  ADDR_W  byte address.
- mem_rd_data  in  8  read data, valid exactly 1 clk after mem_rd_en.
- result_data  out  8*RESULT_BYTES  captured answer, first received bit in the MSB.
- result_valid  out  1  one-clk pulse when result_data is updated.
- busy  out  1  high from the first SS assertion until DONE.
- done  out  1  high in DONE.

Behaviour:
- Mode: CPHA=0 only. MISO changes on the trailing edge; MOSI is sampled on the leading edge.
- Edge detection: leading and trailing edges are detected from the last two synchronised SCLK samples and qualified by synchronised SS low.
- SCLK constraint: period must be at least 8 clk.
- SS setup: SS falling to the first leading edge must be at least 6 clk.
- Reset: every output is 0, except spi_miso, which is 0 with spi_miso_oe=0. Internally, state=PREFETCH, bit counter=DATA_BITS-1, byte address=0, result shift register=0.
- FSM states: PREFETCH, STREAM, CAPTURE, DONE.
- PREFETCH:
  - Issues a read of address 0 on the first clk after reset.
  - The next clk loads the shift register and issues a read of address 1 into the holding register.
  - Goes to STREAM after 2 clk, regardless of SS.
- STREAM:
  - spi_miso = shift register MSB, presented before the first leading edge.
  - Each trailing edge shifts left one bit and decrements the bit counter.
  - When a byte is exhausted, the holding register moves into the shift register and the next address is read the same clk. The holding register is always valid before the next trailing edge.
  - When the counter reaches 0, the next trailing edge enters CAPTURE and forces spi_miso=0.
- DATA_BITS not a multiple of 8:
  - The last byte contributes its upper DATA_BITS mod 8 bits.
  - No read is issued past address ceil(DATA_BITS/8)-1.
- CAPTURE:
  - Each leading edge shifts synchronised MOSI into the LSB of the result shift register.
  - After 8*RESULT_BYTES samples: copy to result_data, pulse result_valid for 1 clk, go to DONE.
  - spi_miso stays 0.
- DONE:
  - Edges are ignored and spi_miso=0.
  - result_data holds.
  - Exit only by rst, which restarts from PREFETCH for a fresh run.
- SS high in any state: spi_miso_oe=0 and edges are ignored, but state, counters and shift registers are retained. Reasserting SS resumes at the same bit.
- spi_miso_oe = synchronised SS low, in all states.
- A simultaneous leading and trailing detection is impossible given the SCLK constraint; no handling is required.
- rst mid-transfer: immediate return to reset values on the next clk. Any partial result is discarded and result_valid is not pulsed.

Decomposition:
- Shared package spi_pkg:
  - FSM state encoding (2 bits).
  - CPHA constant.
  - Minimum SCLK-period and SS-setup constants, used by the bench.
- One sub-module spi_pin_sync:
  - SYNC_STAGES synchroniser for the three inputs.
  - Produces sclk_lead, sclk_trail and ss_active single-clk strobes/levels, honouring CPOL.
  - Reusable by other SPI blocks.

Test Plan:
- Basic run:
  - Setup: DATA_BITS=16, RESULT_BYTES=2, memory {0xA5, 0x3C}, CPOL=0, SCLK period 10 clk.
  - Required response: master sees MISO 1010_0101_0011_1100, then zeros.
  - Then master sends 0x1234: result_data=0x1234, result_valid pulses exactly once, done=1.
- Partial last byte:
  - Setup: DATA_BITS=12, memory {0xF0, 0xE7}.
  - Required response: MISO 1111_0000_1110, then CAPTURE starts on the 12th trailing edge.
  - Address 2 is never read.
- SS pause:
  - Stimulus: deassert SS for 50 clk after bit 5 of 0xA5.
  - Required response: spi_miso_oe=0 during the pause, no state change.
  - After reassertion the stream resumes at bit 6 with identical output.
- CPOL=1:
  - Same stimulus as the basic run with SCLK idling high.
  - Required response: identical MISO bit sequence and result 0x1234.
- Reset mid-capture:
  - Stimulus: assert rst after 9 of 16 result bits.
  - Required response: all outputs 0, no result_valid.
  - A subsequent full run returns a fresh result 0xBEEF.
- DONE hold:
  - Stimulus: after DONE, master clocks 32 more edges with MOSI=1.
  - Required response: result_data is unchanged, spi_miso=0, no extra result_valid.
